time_unit_scaler: RTL

TIME_UNIT_SCALER -- requirements
Module: time_unit_scaler

---
 rtl/time_scale_pkg.sv | 31 +++
 rtl/time_decade_step.sv | 26 ++
 rtl/time_unit_scaler.sv | 121 ++++++++++++
 3 files changed

// File: rtl/time_scale_pkg.sv
// Shared types and limits for the time unit scaler: FSM states, scaling direction,
// legal decimal exponent range and an elaboration-time power-of-ten helper.
package time_scale_pkg;

    localparam int MIN_EXP = -15;
    localparam int MAX_EXP = 2;
    localparam int MAX_K   = 19;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCALE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        DIR_PASS = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_e;

    // Constant function only; never evaluated in hardware.
    function automatic logic [127:0] pow10(input int k);
        logic [127:0] r;
        r = 128'd1;
        for (int i = 0; i < k; i++) begin
            r = r * 128'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/time_decade_step.sv
// One decade of rescaling: x10 with overflow flag, or /10 with remainder.
// Purely combinational, no handshake of its own.
module time_decade_step #(
    parameter int WIDTH = 64
) (
    input  logic             up_i,
    input  logic [WIDTH-1:0] val_i,
    output logic [WIDTH-1:0] res_o,
    output logic             ovf_o,
    output logic [3:0]       rem_o
);

    localparam logic [WIDTH+3:0] TEN_X = (WIDTH+4)'(10);
    localparam logic [WIDTH-1:0] TEN_W = WIDTH'(10);

    logic [WIDTH+3:0] prod;
    logic [WIDTH-1:0] quot;

    assign prod  = {4'b0000, val_i} * TEN_X;
    assign quot  = val_i / TEN_W;

    assign res_o = up_i ? prod[WIDTH-1:0] : quot;
    assign ovf_o = up_i & (|prod[WIDTH+3:WIDTH]);
    assign rem_o = up_i ? 4'd0 : 4'(val_i % TEN_W);

endmodule

// File: rtl/time_unit_scaler.sv
// Rescales a tick count between decimal time units, one decade per clock; out_valid follows
// the accept cycle by K+1 cycles. One transaction in flight; in_ready only when idle, result held until out_ready.
module time_unit_scaler
    import time_scale_pkg::*;
#(
    parameter int SRC_EXP = -12,
    parameter int DST_EXP = -10,
    parameter int WIDTH   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_time,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_time,
    output logic             out_overflow
);

    localparam int K = (SRC_EXP > DST_EXP) ? (SRC_EXP - DST_EXP) : (DST_EXP - SRC_EXP);
    localparam dir_e DIR = (SRC_EXP > DST_EXP) ? DIR_UP :
                           (SRC_EXP < DST_EXP) ? DIR_DOWN : DIR_PASS;
    localparam logic [127:0] POW10_K = pow10(K);

    if (SRC_EXP < MIN_EXP || SRC_EXP > MAX_EXP ||
        DST_EXP < MIN_EXP || DST_EXP > MAX_EXP ||
        K > MAX_K || POW10_K > pow10(MAX_K)) begin : g_bad_exp
        $error("time_unit_scaler: exponents must lie in [-15,2] with a span of at most 19 decades");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;
    logic [4:0]       cnt_q, cnt_d;

    logic [WIDTH-1:0] step_res;
    logic             step_ovf;
    logic [3:0]       step_rem;
    logic [WIDTH:0]   round_sum;

    time_decade_step #(.WIDTH(WIDTH)) u_step (
        .up_i  (DIR == DIR_UP),
        .val_i (data_q),
        .res_o (step_res),
        .ovf_o (step_ovf),
        .rem_o (step_rem)
    );

    assign round_sum = {1'b0, step_res} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d = in_time;
                    ovf_d  = 1'b0;
                    cnt_d  = 5'(K);
                    state_d = (K == 0) ? ST_DONE : ST_SCALE;
                end
            end
            ST_SCALE: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = ST_DONE;
                end
                if (DIR == DIR_UP) begin
                    // Once saturated, keep running the remaining steps so latency never varies.
                    if (ovf_q || step_ovf) begin
                        data_d = '1;
                        ovf_d  = 1'b1;
                    end else begin
                        data_d = step_res;
                    end
                end else begin
                    // Earlier steps truncate; only the final remainder decides rounding.
                    if (cnt_q == 5'd1 && step_rem >= 4'd5) begin
                        if (round_sum[WIDTH]) begin
                            data_d = '1;
                            ovf_d  = 1'b1;
                        end else begin
                            data_d = round_sum[WIDTH-1:0];
                        end
                    end else begin
                        data_d = step_res;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_DONE);
    assign out_time     = data_q;
    assign out_overflow = ovf_q;

endmodule
